// File: rtl/rv_mem_arbiter.sv
// rv_mem_arbiter
//   Shares one 32-bit single-port memory bus between the instruction-fetch
//   port and the data port. Data requests have priority. After MAX_D_STREAK
//   consecutive data grants while a fetch is waiting, the fetch is granted.
//   The block steers byte lanes for BYTE/HWORD/WORD accesses and extends
//   load data. It also reports misaligned or illegal accesses without
//   touching the bus.
//
// Handshakes (one description for every port):
//   - Requester side (if_*, d_*): req is held high, with its operands
//     stable, until the matching done pulse. The done cycle is also the
//     first cycle in which the arbiter evaluates new requests. A requester
//     that keeps req high in its done cycle is therefore presenting a new
//     transaction.
//   - Bus side: bus_req_o and its addr/be/we/wdata are registered and held
//     until bus_ack_i. bus_rdata_i is valid in the ack cycle. An ack that
//     arrives while no bus request is outstanding is ignored.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   if_req_i/if_addr_i       fetch request and address
//   if_done_o/if_rdata_o/if_err_o   fetch completion pulse, data, error
//   d_req_i/d_we_i/d_addr_i/d_wdata_i/d_sz_i/d_sign_ext_i   data request
//   d_done_o/d_rdata_o/d_err_o      data completion pulse, load data, error
//   stall_o                  pipeline stall while the MEM access is unfinished
//   bus_req_o/bus_we_o/bus_addr_o/bus_be_o/bus_wdata_o   memory bus request
//   bus_ack_i/bus_rdata_i    memory bus completion and read data
//
// Debug: state_q (IDLE/IF_BUSY/D_BUSY/ERR_RESP) and streak_q are plain
// registers, so checkers can bind to them directly.

module rv_mem_arbiter #(
  parameter int ADDR_W       = 64,
  parameter int MAX_D_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_done_o,
  output logic [31:0]       if_rdata_o,
  output logic              if_err_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [31:0]       d_wdata_i,
  input  logic [1:0]        d_sz_i,
  input  logic              d_sign_ext_i,
  output logic              d_done_o,
  output logic [31:0]       d_rdata_o,
  output logic              d_err_o,
  output logic              stall_o,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [3:0]        bus_be_o,
  output logic [31:0]       bus_wdata_o,
  input  logic              bus_ack_i,
  input  logic [31:0]       bus_rdata_i
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_IF_BUSY  = 2'd1;
  localparam logic [1:0] S_D_BUSY   = 2'd2;
  localparam logic [1:0] S_ERR_RESP = 2'd3;

  localparam logic [1:0] SZ_WORD  = 2'd0;
  localparam logic [1:0] SZ_HWORD = 2'd1;
  localparam logic [1:0] SZ_BYTE  = 2'd2;

  localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);

  logic [1:0]        state_q, state_d;
  logic [3:0]        streak_q, streak_d;
  // Owner of the current transaction: 1 = data port, 0 = fetch port.
  logic              own_d_q, own_d_d;
  // Load-shaping info captured at grant so the ack path does not depend
  // on the requester still holding its inputs.
  logic [1:0]        off_q, off_d;
  logic [1:0]        sz_q, sz_d;
  logic              sext_q, sext_d;
  logic              st_q, st_d;

  logic              bus_req_q, bus_req_d;
  logic              bus_we_q, bus_we_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [3:0]        bus_be_q, bus_be_d;
  logic [31:0]       bus_wdata_q, bus_wdata_d;

  logic              if_done_q, if_done_d;
  logic [31:0]       if_rdata_q, if_rdata_d;
  logic              if_err_q, if_err_d;
  logic              d_done_q, d_done_d;
  logic [31:0]       d_rdata_q, d_rdata_d;
  logic              d_err_q, d_err_d;

  // Data request decode: lane enables, replicated store data, error.
  logic [3:0]        d_be;
  logic [31:0]       d_wrep;
  logic              d_bad;

  always_comb begin
    d_be   = 4'b0000;
    d_wrep = 32'h0;
    d_bad  = 1'b1;
    case (d_sz_i)
      SZ_WORD: begin
        d_be   = 4'b1111;
        d_wrep = d_wdata_i;
        d_bad  = (d_addr_i[1:0] != 2'b00);
      end
      SZ_HWORD: begin
        d_be   = 4'b0011 << d_addr_i[1:0];
        d_wrep = {2{d_wdata_i[15:0]}};
        d_bad  = d_addr_i[0];
      end
      SZ_BYTE: begin
        d_be   = 4'b0001 << d_addr_i[1:0];
        d_wrep = {4{d_wdata_i[7:0]}};
        d_bad  = 1'b0;
      end
      default: ;
    endcase
  end

  // Load path: bring the addressed lane down to bit 0, then extend.
  logic [31:0] ld_shift;
  logic [31:0] ld_ext;

  assign ld_shift = bus_rdata_i >> {off_q, 3'b000};

  always_comb begin
    case (sz_q)
      SZ_BYTE:  ld_ext = {{24{sext_q & ld_shift[7]}}, ld_shift[7:0]};
      SZ_HWORD: ld_ext = {{16{sext_q & ld_shift[15]}}, ld_shift[15:0]};
      default:  ld_ext = ld_shift;
    endcase
  end

  // The fetch port wins only when it is waiting and data has used up its
  // allowed streak.
  logic pick_d;
  logic pick_if;

  assign pick_d  = d_req_i && !(if_req_i && (streak_q == STREAK_MAX));
  assign pick_if = if_req_i && !pick_d;

  always_comb begin
    state_d     = state_q;
    streak_d    = streak_q;
    own_d_d     = own_d_q;
    off_d       = off_q;
    sz_d        = sz_q;
    sext_d      = sext_q;
    st_d        = st_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_be_d    = bus_be_q;
    bus_wdata_d = bus_wdata_q;
    if_done_d   = 1'b0;
    if_rdata_d  = if_rdata_q;
    if_err_d    = if_err_q;
    d_done_d    = 1'b0;
    d_rdata_d   = d_rdata_q;
    d_err_d     = d_err_q;

    case (state_q)
      S_IDLE: begin
        if (!if_req_i) begin
          streak_d = 4'd0;
        end
        if (pick_d) begin
          if (if_req_i) begin
            streak_d = streak_q + 4'd1;
          end
          own_d_d = 1'b1;
          off_d   = d_addr_i[1:0];
          sz_d    = d_sz_i;
          sext_d  = d_sign_ext_i;
          st_d    = d_we_i;
          if (d_bad) begin
            state_d = S_ERR_RESP;
          end else begin
            state_d     = S_D_BUSY;
            bus_req_d   = 1'b1;
            bus_we_d    = d_we_i;
            bus_addr_d  = {d_addr_i[ADDR_W-1:2], 2'b00};
            bus_be_d    = d_be;
            bus_wdata_d = d_we_i ? d_wrep : 32'h0;
          end
        end else if (pick_if) begin
          streak_d = 4'd0;
          own_d_d  = 1'b0;
          if (if_addr_i[1:0] != 2'b00) begin
            state_d = S_ERR_RESP;
          end else begin
            state_d     = S_IF_BUSY;
            bus_req_d   = 1'b1;
            bus_we_d    = 1'b0;
            bus_addr_d  = if_addr_i;
            bus_be_d    = 4'b1111;
            bus_wdata_d = 32'h0;
          end
        end
      end

      S_IF_BUSY: begin
        if (bus_ack_i) begin
          state_d    = S_IDLE;
          bus_req_d  = 1'b0;
          bus_we_d   = 1'b0;
          if_done_d  = 1'b1;
          if_err_d   = 1'b0;
          if_rdata_d = bus_rdata_i;
        end
      end

      S_D_BUSY: begin
        if (bus_ack_i) begin
          state_d   = S_IDLE;
          bus_req_d = 1'b0;
          bus_we_d  = 1'b0;
          d_done_d  = 1'b1;
          d_err_d   = 1'b0;
          d_rdata_d = st_q ? 32'h0 : ld_ext;
        end
      end

      default: begin // S_ERR_RESP: answer the offending port, no bus cycle
        state_d = S_IDLE;
        if (own_d_q) begin
          d_done_d  = 1'b1;
          d_err_d   = 1'b1;
          d_rdata_d = 32'h0;
        end else begin
          if_done_d  = 1'b1;
          if_err_d   = 1'b1;
          if_rdata_d = 32'h0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      streak_q    <= 4'd0;
      own_d_q     <= 1'b0;
      off_q       <= 2'd0;
      sz_q        <= 2'd0;
      sext_q      <= 1'b0;
      st_q        <= 1'b0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_be_q    <= 4'd0;
      bus_wdata_q <= 32'h0;
      if_done_q   <= 1'b0;
      if_rdata_q  <= 32'h0;
      if_err_q    <= 1'b0;
      d_done_q    <= 1'b0;
      d_rdata_q   <= 32'h0;
      d_err_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      streak_q    <= streak_d;
      own_d_q     <= own_d_d;
      off_q       <= off_d;
      sz_q        <= sz_d;
      sext_q      <= sext_d;
      st_q        <= st_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_be_q    <= bus_be_d;
      bus_wdata_q <= bus_wdata_d;
      if_done_q   <= if_done_d;
      if_rdata_q  <= if_rdata_d;
      if_err_q    <= if_err_d;
      d_done_q    <= d_done_d;
      d_rdata_q   <= d_rdata_d;
      d_err_q     <= d_err_d;
    end
  end

  assign if_done_o   = if_done_q;
  assign if_rdata_o  = if_rdata_q;
  assign if_err_o    = if_err_q;
  assign d_done_o    = d_done_q;
  assign d_rdata_o   = d_rdata_q;
  assign d_err_o     = d_err_q;
  assign stall_o     = d_req_i & ~d_done_q;
  assign bus_req_o   = bus_req_q;
  assign bus_we_o    = bus_we_q;
  assign bus_addr_o  = bus_addr_q;
  assign bus_be_o    = bus_be_q;
  assign bus_wdata_o = bus_wdata_q;

endmodule

// File: tb/tb_rv_mem_arbiter.sv
// Testbench for rv_mem_arbiter: table-driven directed vectors, hand-written
// multi-cycle sequences (reset mid-transaction, fetch, arbitration streak)
// and randomized single transactions checked against a behavioural model.

module tb_rv_mem_arbiter;

  localparam int AW = 64;

  logic          clk;
  logic          rst;
  logic          if_req_i;
  logic [AW-1:0] if_addr_i;
  logic          if_done_o;
  logic [31:0]   if_rdata_o;
  logic          if_err_o;
  logic          d_req_i;
  logic          d_we_i;
  logic [AW-1:0] d_addr_i;
  logic [31:0]   d_wdata_i;
  logic [1:0]    d_sz_i;
  logic          d_sign_ext_i;
  logic          d_done_o;
  logic [31:0]   d_rdata_o;
  logic          d_err_o;
  logic          stall_o;
  logic          bus_req_o;
  logic          bus_we_o;
  logic [AW-1:0] bus_addr_o;
  logic [3:0]    bus_be_o;
  logic [31:0]   bus_wdata_o;
  logic          bus_ack_i;
  logic [31:0]   bus_rdata_i;

  rv_mem_arbiter #(.ADDR_W(AW), .MAX_D_STREAK(4)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i),
    .if_done_o(if_done_o), .if_rdata_o(if_rdata_o), .if_err_o(if_err_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i),
    .d_wdata_i(d_wdata_i), .d_sz_i(d_sz_i), .d_sign_ext_i(d_sign_ext_i),
    .d_done_o(d_done_o), .d_rdata_o(d_rdata_o), .d_err_o(d_err_o),
    .stall_o(stall_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
    .bus_be_o(bus_be_o), .bus_wdata_o(bus_wdata_o),
    .bus_ack_i(bus_ack_i), .bus_rdata_i(bus_rdata_i)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- scoreboard bookkeeping ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- bus responder state ----------------
  int          ack_lat;
  int          wait_cnt;
  logic [31:0] resp_word;
  int          ack_cnt;
  logic [63:0] log_addr;
  logic [3:0]  log_be;
  logic        log_we;
  logic [31:0] log_wdata;
  logic        hold_chk;
  logic [63:0] hold_addr;
  logic [36:0] hold_misc;

  // One clock step: sample outputs 1 ns after the edge, check invariants,
  // then let the bus model decide the ack for the current cycle.
  task automatic tick();
    @(posedge clk);
    #1;
    chk("stall", stall_o, d_req_i & ~d_done_o);
    if (hold_chk && !rst) begin
      chk("bus_hold_addr", bus_addr_o, hold_addr);
      chk("bus_hold_ctrl", {bus_be_o, bus_we_o, bus_wdata_o}, hold_misc);
    end
    if (bus_ack_i) begin
      bus_ack_i = 1'b0;
      wait_cnt  = 0;
    end else if (bus_req_o) begin
      if (wait_cnt >= ack_lat) begin
        bus_ack_i   = 1'b1;
        bus_rdata_i = resp_word;
        ack_cnt++;
        log_addr  = bus_addr_o;
        log_be    = bus_be_o;
        log_we    = bus_we_o;
        log_wdata = bus_wdata_o;
        wait_cnt  = 0;
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
    hold_chk  = bus_req_o && !bus_ack_i;
    hold_addr = bus_addr_o;
    hold_misc = {bus_be_o, bus_we_o, bus_wdata_o};
  endtask

  // ---------------- behavioural reference model ----------------
  function automatic int nbytes(input logic [1:0] sz);
    return 4 >> sz;
  endfunction

  function automatic logic m_err(input logic [1:0] sz, input logic [1:0] off);
    if (sz == 2'd3) return 1'b1;
    return (int'(off) % nbytes(sz)) != 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [1:0] off);
    int n;
    n = nbytes(sz);
    return 4'(((1 << n) - 1) << off);
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] wd);
    logic [31:0] r;
    int n;
    n = nbytes(sz);
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_rdata(input logic [1:0] sz, input logic [1:0] off,
                                          input logic sx, input logic [31:0] word);
    longint v;
    int n;
    n = nbytes(sz);
    v = longint'(word) >> (8 * int'(off));
    if (n < 4) begin
      v = v % (longint'(1) << (8 * n));
      if (sx && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
    end
    return v[31:0];
  endfunction

  // ---------------- driver tasks ----------------
  task automatic run_d(input logic we, input logic [63:0] addr, input logic [31:0] wd,
                       input logic [1:0] sz, input logic sx, input logic [31:0] word,
                       input int lat, output logic [31:0] rd, output logic er,
                       output int cyc, output int nacks);
    int a0;
    logic got;
    a0 = ack_cnt;
    resp_word = word;
    ack_lat = lat;
    d_we_i = we; d_addr_i = addr; d_wdata_i = wd; d_sz_i = sz; d_sign_ext_i = sx;
    d_req_i = 1'b1;
    cyc = 0; got = 1'b0; rd = 32'h0; er = 1'b0;
    while (!got && cyc < 100) begin
      tick();
      cyc++;
      if (d_done_o) begin
        got = 1'b1;
        rd = d_rdata_o;
        er = d_err_o;
      end
    end
    d_req_i = 1'b0;
    chk("d_done_seen", got, 1'b1);
    nacks = ack_cnt - a0;
  endtask

  task automatic run_if(input logic [63:0] addr, input logic [31:0] word, input int lat,
                        output logic [31:0] rd, output logic er, output int cyc,
                        output int nacks);
    int a0;
    logic got;
    a0 = ack_cnt;
    resp_word = word;
    ack_lat = lat;
    if_addr_i = addr;
    if_req_i = 1'b1;
    cyc = 0; got = 1'b0; rd = 32'h0; er = 1'b0;
    while (!got && cyc < 100) begin
      tick();
      cyc++;
      if (if_done_o) begin
        got = 1'b1;
        rd = if_rdata_o;
        er = if_err_o;
      end
    end
    if_req_i = 1'b0;
    chk("if_done_seen", got, 1'b1);
    nacks = ack_cnt - a0;
  endtask

  // Runs one data transaction and compares against supplied expectations.
  task automatic check_d(input string tag, input logic we, input logic [63:0] addr,
                         input logic [31:0] wd, input logic [1:0] sz, input logic sx,
                         input logic [31:0] word, input int lat, input logic e_err,
                         input logic [3:0] e_be, input logic [31:0] e_bw,
                         input logic [31:0] e_rd);
    logic [31:0] rd;
    logic er;
    int cyc, nacks;
    run_d(we, addr, wd, sz, sx, word, lat, rd, er, cyc, nacks);
    chk({tag, "_err"}, er, e_err);
    chk({tag, "_lat"}, cyc, e_err ? 2 : 2 + lat);
    chk({tag, "_nbus"}, nacks, e_err ? 0 : 1);
    if (e_err) begin
      chk({tag, "_rdata0"}, rd, 32'h0);
    end else begin
      chk({tag, "_baddr"}, log_addr, {addr[63:2], 2'b00});
      chk({tag, "_be"}, log_be, e_be);
      chk({tag, "_we"}, log_we, we);
      if (we) chk({tag, "_bwdata"}, log_wdata, e_bw);
      else    chk({tag, "_rdata"}, rd, e_rd);
    end
  endtask

  task automatic check_if(input string tag, input logic [63:0] addr,
                          input logic [31:0] word, input int lat);
    logic [31:0] rd;
    logic er, e_err;
    int cyc, nacks;
    e_err = (addr[1:0] != 2'b00);
    run_if(addr, word, lat, rd, er, cyc, nacks);
    chk({tag, "_err"}, er, e_err);
    chk({tag, "_lat"}, cyc, e_err ? 2 : 2 + lat);
    chk({tag, "_nbus"}, nacks, e_err ? 0 : 1);
    chk({tag, "_rdata"}, rd, e_err ? 32'h0 : word);
    if (!e_err) begin
      chk({tag, "_baddr"}, log_addr, addr);
      chk({tag, "_be"}, log_be, 4'b1111);
      chk({tag, "_we"}, log_we, 1'b0);
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        we;
    logic [63:0] addr;
    logic [31:0] wd;
    logic [1:0]  sz;
    logic        sx;
    logic [31:0] word;
    int          lat;
    logic        e_err;
    logic [3:0]  e_be;
    logic [31:0] e_bw;
    logic [31:0] e_rd;
  } vec_t;

  localparam int NV = 14;
  vec_t tbl [NV];

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] rd;
    logic er;
    int cyc, nacks;
    int exp_q[$];
    int got_q[$];

    rst = 1'b1;
    if_req_i = 1'b0; if_addr_i = '0;
    d_req_i = 1'b0; d_we_i = 1'b0; d_addr_i = '0; d_wdata_i = 32'h0;
    d_sz_i = 2'd0; d_sign_ext_i = 1'b0;
    bus_ack_i = 1'b0; bus_rdata_i = 32'h0;
    ack_lat = 0; wait_cnt = 0; resp_word = 32'h0; ack_cnt = 0;
    log_addr = '0; log_be = '0; log_we = 1'b0; log_wdata = '0;
    hold_chk = 1'b0; hold_addr = '0; hold_misc = '0;

    // Reset state: every output low.
    repeat (3) tick();
    chk("rst_if_done", if_done_o, 1'b0);
    chk("rst_d_done", d_done_o, 1'b0);
    chk("rst_bus_req", bus_req_o, 1'b0);
    chk("rst_bus_we", bus_we_o, 1'b0);
    chk("rst_bus_addr", bus_addr_o, 64'h0);
    chk("rst_bus_be", bus_be_o, 4'h0);
    chk("rst_bus_wdata", bus_wdata_o, 32'h0);
    chk("rst_rdata", {if_rdata_o, d_rdata_o}, 64'h0);
    chk("rst_err", {if_err_o, d_err_o}, 2'b00);
    rst = 1'b0;
    tick();

    // Reset in the middle of a data bus cycle, then a late ack.
    ack_lat = 1000;
    d_we_i = 1'b0; d_addr_i = 64'h2000; d_sz_i = 2'd0; d_sign_ext_i = 1'b0;
    d_req_i = 1'b1;
    tick();
    tick();
    chk("midrst_bus_req_before", bus_req_o, 1'b1);
    rst = 1'b1;
    tick();
    chk("midrst_bus_req_in_rst", bus_req_o, 1'b0);
    rst = 1'b0;
    d_req_i = 1'b0;
    tick();
    bus_ack_i = 1'b1;
    bus_rdata_i = 32'hDEADBEEF;
    tick();
    chk("midrst_no_done", d_done_o, 1'b0);
    chk("midrst_bus_idle", bus_req_o, 1'b0);
    tick();
    chk("midrst_no_done2", d_done_o, 1'b0);
    chk("midrst_bus_idle2", bus_req_o, 1'b0);
    check_if("midrst_if", 64'h1000, 32'h13579BDF, 1);

    // Fetch: acked two cycles after bus_req_o, then a misaligned fetch.
    check_if("if_basic", 64'h1000, 32'h00500093, 2);
    check_if("if_misal", 64'h1002, 32'h11111111, 0);

    // Directed data vectors (expected values worked out by hand).
    tbl[0]  = '{1'b0, 64'h2003, 32'h0,        2'd2, 1'b1, 32'h80112233, 1, 1'b0, 4'b1000, 32'h0,        32'hFFFFFF80};
    tbl[1]  = '{1'b0, 64'h2003, 32'h0,        2'd2, 1'b0, 32'h80112233, 1, 1'b0, 4'b1000, 32'h0,        32'h00000080};
    tbl[2]  = '{1'b1, 64'h3002, 32'h0000ABCD, 2'd1, 1'b0, 32'h0,        1, 1'b0, 4'b1100, 32'hABCDABCD, 32'h0};
    tbl[3]  = '{1'b0, 64'h4001, 32'h0,        2'd0, 1'b0, 32'h0,        1, 1'b1, 4'b0000, 32'h0,        32'h0};
    tbl[4]  = '{1'b0, 64'h4000, 32'h0,        2'd3, 1'b0, 32'h0,        1, 1'b1, 4'b0000, 32'h0,        32'h0};
    tbl[5]  = '{1'b0, 64'h5001, 32'h0,        2'd1, 1'b1, 32'h0,        1, 1'b1, 4'b0000, 32'h0,        32'h0};
    tbl[6]  = '{1'b0, 64'h5002, 32'h0,        2'd1, 1'b1, 32'h80017FFF, 0, 1'b0, 4'b1100, 32'h0,        32'hFFFF8001};
    tbl[7]  = '{1'b1, 64'h6001, 32'h000000A5, 2'd2, 1'b0, 32'h0,        2, 1'b0, 4'b0010, 32'hA5A5A5A5, 32'h0};
    tbl[8]  = '{1'b1, 64'h7000, 32'h12345678, 2'd0, 1'b0, 32'h0,        0, 1'b0, 4'b1111, 32'h12345678, 32'h0};
    tbl[9]  = '{1'b0, 64'h5000, 32'h0,        2'd1, 1'b0, 32'h1234F00D, 1, 1'b0, 4'b0011, 32'h0,        32'h0000F00D};
    tbl[10] = '{1'b0, 64'h5000, 32'h0,        2'd1, 1'b1, 32'h1234F00D, 1, 1'b0, 4'b0011, 32'h0,        32'hFFFFF00D};
    tbl[11] = '{1'b0, 64'h8000, 32'h0,        2'd0, 1'b1, 32'h87654321, 3, 1'b0, 4'b1111, 32'h0,        32'h87654321};
    tbl[12] = '{1'b0, 64'h2001, 32'h0,        2'd2, 1'b1, 32'h80112233, 1, 1'b0, 4'b0010, 32'h0,        32'h00000022};
    tbl[13] = '{1'b1, 64'h7002, 32'h12345678, 2'd0, 1'b0, 32'h0,        1, 1'b1, 4'b0000, 32'h0,        32'h0};
    for (int i = 0; i < NV; i++) begin
      check_d($sformatf("vec%0d", i), tbl[i].we, tbl[i].addr, tbl[i].wd, tbl[i].sz,
              tbl[i].sx, tbl[i].word, tbl[i].lat, tbl[i].e_err, tbl[i].e_be,
              tbl[i].e_bw, tbl[i].e_rd);
      tick();
    end

    // Both ports held continuously with single-cycle acks: the fetch port
    // must get one grant after every MAX_D_STREAK data grants.
    ack_lat = 0;
    resp_word = 32'h0;
    d_we_i = 1'b0; d_addr_i = 64'h100; d_sz_i = 2'd0; d_sign_ext_i = 1'b0;
    if_addr_i = 64'h1000;
    d_req_i = 1'b1;
    if_req_i = 1'b1;
    for (int c = 0; c < 200 && got_q.size() < 15; c++) begin
      tick();
      if (d_done_o) got_q.push_back(0);
      if (if_done_o) got_q.push_back(1);
    end
    d_req_i = 1'b0;
    if_req_i = 1'b0;
    begin
      int s;
      s = 0;
      for (int k = 0; k < 15; k++) begin
        if (s == 4) begin exp_q.push_back(1); s = 0; end
        else begin exp_q.push_back(0); s++; end
      end
    end
    chk("streak_count", got_q.size(), 15);
    for (int k = 0; k < 15 && k < got_q.size(); k++)
      chk($sformatf("streak_order%0d", k), got_q[k], exp_q[k]);
    repeat (6) tick();

    // Both requests raised together with a short data streak: data first,
    // then fetch in the first idle evaluation after the data done.
    ack_lat = 0;
    d_addr_i = 64'h200; d_sz_i = 2'd0; d_we_i = 1'b0;
    if_addr_i = 64'h1004;
    d_req_i = 1'b1;
    if_req_i = 1'b1;
    begin
      int dc, ic;
      dc = -1; ic = -1;
      for (int c = 1; c <= 20 && ic < 0; c++) begin
        tick();
        if (d_done_o) begin dc = c; d_req_i = 1'b0; end
        if (if_done_o) begin ic = c; if_req_i = 1'b0; end
      end
      d_req_i = 1'b0;
      if_req_i = 1'b0;
      chk("pair_d_cycle", dc, 2);
      chk("pair_if_cycle", ic, 4);
    end
    tick();

    // Randomized single transactions against the behavioural model.
    for (int t = 0; t < 200; t++) begin
      logic [63:0] a;
      logic [1:0] sz, off;
      logic we, sx, e_err;
      logic [31:0] wd, word;
      int lat, r, n;
      a = {$urandom, $urandom};
      word = $urandom;
      lat = $urandom_range(0, 3);
      if ($urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
        check_if($sformatf("rnd_if%0d", t), a, word, lat);
      end else begin
        r = $urandom_range(0, 9);
        sz = (r == 0) ? 2'd3 : 2'(r % 3);
        we = 1'($urandom_range(0, 1));
        sx = 1'($urandom_range(0, 1));
        wd = $urandom;
        n = (sz == 2'd3) ? 1 : nbytes(sz);
        off = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 3) != 0) off = 2'(int'(off) - (int'(off) % n));
        a[1:0] = off;
        e_err = m_err(sz, off);
        check_d($sformatf("rnd_d%0d", t), we, a, wd, sz, sx, word, lat, e_err,
                e_err ? 4'b0 : m_be(sz, off), e_err ? 32'h0 : m_wdata(sz, wd),
                e_err ? 32'h0 : m_rdata(sz, off, sx, word));
      end
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rv_mem_arbiter.md
Name: rv_mem_arbiter

Overview:
- Shares one 32-bit single-port memory bus between the instruction-fetch port (IF stage) and the data port (MEM stage).
- Arbitrates requests with data priority plus an anti-starvation limit, and runs a req/ack bus handshake through an FSM.
- Performs byte-lane steering for BYTE/HWORD/WORD accesses and sign/zero extension on loads.
- Drives the pipeline stall signal while the MEM-stage access is unfinished.

Parameters:
- ADDR_W, 64, address width of ports and bus.
- MAX_D_STREAK, 4, max consecutive data grants while an IF request waits; range 1..15.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- if_req_i  in  1  fetch request; held with if_addr_i stable until if_done_o.
- if_addr_i  in  ADDR_W  fetch address.
- if_done_o  out  1  one-cycle completion pulse for fetch.
- if_rdata_o  out  32  fetched instruction; valid with if_done_o.
- if_err_o  out  1  fetch misaligned (addr[1:0]!=0); valid with if_done_o.
- d_req_i  in  1  data request; held with all d_* inputs stable until d_done_o.
- d_we_i  in  1  1=store, 0=load.
- d_addr_i  in  ADDR_W  byte address.
- d_wdata_i  in  32  store data, right-aligned.
- d_sz_i  in  2  access size: 0=WORD, 1=HWORD, 2=BYTE, 3=illegal.
- d_sign_ext_i  in  1  load sign-extend enable.
- d_done_o  out  1  one-cycle completion pulse for data.
- d_rdata_o  out  32  extended load data; valid with d_done_o when loading.
- d_err_o  out  1  misaligned or illegal size; valid with d_done_o.
- stall_o  out  1  d_req_i & ~d_done_o (combinational).
- bus_req_o  out  1  bus request, registered.
- bus_we_o  out  1  bus write enable, registered.
- bus_addr_o  out  ADDR_W  word address, bits [1:0]=0, registered.
- bus_be_o  out  4  byte enables, registered.
- bus_wdata_o  out  32  lane-steered store data, registered.
- bus_ack_i  in  1  bus completion; bus_rdata_i valid in the same cycle.
- bus_rdata_i  in  32  bus read word.

Behaviour:
- Reset:
  - State=IDLE; streak counter=0.
  - All outputs 0.
  - rst overrides any transaction in flight; bus_ack_i arriving after reset is ignored.
- States: IDLE, IF_BUSY, D_BUSY, ERR_RESP.
- Arbitration (IDLE only):
  - d_req_i wins unless if_req_i=1 and streak==MAX_D_STREAK; in that case IF wins.
  - The streak counter increments on each data grant while if_req_i=1.
  - The streak counter clears on any IF grant, and whenever if_req_i=0 in IDLE.
- Error check at grant:
  - Illegal d_sz=3 -> error.
  - HWORD with addr[0]!=0 -> error.
  - WORD with addr[1:0]!=0 -> error.
  - IF with addr[1:0]!=0 -> error.
  - On error: go to ERR_RESP, no bus activity; next cycle pulse the done for that port with err=1 and rdata=0; return to IDLE.
- Legal grant in cycle N:
  - Enter IF_BUSY or D_BUSY; bus_req_o=1 from cycle N+1, along with registered addr, be and wdata.
  - Outputs hold stable until ack.
- Ack:
  - bus_ack_i=1 in a BUSY state at cycle M: bus_req_o=0 and done=1 at M+1, rdata registered; state=IDLE at M+1.
  - A new grant may be evaluated in cycle M+1, so bus_req_o can go high again at M+2.
  - bus_ack_i in IDLE or ERR_RESP is ignored.
- Byte enables, with off=addr[1:0]:
  - WORD: 1111.
  - HWORD: 0011<<off.
  - BYTE: 0001<<off.
  - Fetch: 1111, we=0.
- Store data: wdata replicated — BYTE {4{b}}, HWORD {2{h}}, WORD as-is.
- Load data:
  - Shift bus_rdata_i right by 8*off.
  - Truncate to size, then sign-extend (d_sign_ext_i=1) or zero-extend to 32.
  - WORD loads are never extended.
- Stall: d_done_o and stall_o are never both 1 in the same cycle.
- Requester drops req before done: protocol violation. The transaction completes anyway and done still pulses.
- Simultaneous IF and data requests with streak<MAX: data first, IF granted in the first IDLE evaluation after d_done_o.

Test Plan:
- Reset mid-D_BUSY (bus_req_o=1), then ack one cycle after rst deasserts -> no d_done_o; bus_req_o=0; IF req then granted normally.
- IF req, addr=0x1000, bus acks 2 cycles after bus_req_o with 0x00500093 -> if_done_o pulse, if_rdata_o=0x00500093, if_err_o=0; bus_addr_o=0x1000, be=1111.
- Signed byte load at addr 0x2003, bus_rdata=0x80112233 -> be=1000, bus_addr=0x2000, d_rdata_o=0xFFFFFF80; same load unsigned -> 0x00000080.
- HWORD store at 0x3002, wdata=0x0000ABCD -> bus_we=1, be=1100, bus_wdata=0xABCDABCD, d_done_o one cycle after ack, stall_o high until then.
- WORD load at 0x4001 -> no bus_req_o; d_done_o with d_err_o=1 two cycles after request; d_sz=3 gives the same response.
- IF and data both held continuously, MAX_D_STREAK=4, single-cycle acks -> grant order D,D,D,D,IF,D,D,D,D,IF...; IF never waits more than 4 data transactions.
